cache_mem_arbiter: RTL and testbench

//  Sits between the I-cache and D-cache fill FSMs and the single-ported main memory.

---
 rtl/cache_mem_arbiter_if.sv | 40 ++++
 rtl/cache_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// Bundle between the I/D-cache fill FSMs, the arbiter and single-ported main memory.
// slave = arbiter view; master = cache/memory environment view.
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_grant;
  logic              i_data_valid;
  logic              i_fill_done;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_wr;
  logic [ADDR_W-1:0] d_wr_addr;
  logic [DATA_W-1:0] d_wr_data;
  logic              d_grant;
  logic              d_data_valid;
  logic              d_fill_done;
  logic              d_wr_ack;
  logic [DATA_W-1:0] rd_data;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_wr, d_wr_addr, d_wr_data, mem_rdata, mem_valid,
    output i_grant, i_data_valid, i_fill_done, d_grant, d_data_valid, d_fill_done,
           d_wr_ack, rd_data, mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, d_wr, d_wr_addr, d_wr_data, mem_rdata, mem_valid,
    input  i_grant, i_data_valid, i_fill_done, d_grant, d_data_valid, d_fill_done,
           d_wr_ack, rd_data, mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I/D line fills and D write-through stores onto one memory port (ARB_RR_EN: round-robin fills).
// Latency: grant/first read 1 cycle after request sampled; data_valid/done combinational from mem_valid.
// Backpressure: requests are levels held until served; losers and stores wait in IDLE, no data is dropped.
module cache_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8
) (
  input logic             clk,
  input logic             rst_n,
  cache_mem_arbiter_if.slave bus
);

  localparam int              CW        = $clog2(WORDS) + 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(2 * WORDS - 1);
  localparam logic [CW-1:0]   CNT_FULL  = CW'(WORDS);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, FILL} state_t;

  state_t            state_q, state_d;
  logic              owner_d_q;
  logic              pick_d;
  logic              issue;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [CW-1:0]     iss_cnt_q;
  logic [CW-1:0]     ret_cnt_q;

`ifdef ARB_RR_EN
  // Set when the previous fill went to the D-cache; reset value favours D first.
  logic last_fill_d_q;
  always_comb pick_d = bus.d_req && !(bus.i_req && last_fill_d_q);
`else
  always_comb pick_d = bus.d_req;
`endif

  assign bus.rd_data = bus.mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    issue            = 1'b0;
    bus.i_grant      = 1'b0;
    bus.i_data_valid = 1'b0;
    bus.i_fill_done  = 1'b0;
    bus.d_grant      = 1'b0;
    bus.d_data_valid = 1'b0;
    bus.d_fill_done  = 1'b0;
    bus.d_wr_ack     = 1'b0;
    bus.mem_en       = 1'b0;
    bus.mem_wr       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    case (state_q)
      IDLE: begin
        if (bus.d_wr)                    state_d = WRITE;
        else if (bus.d_req || bus.i_req) state_d = FILL;
      end
      WRITE: begin
        bus.mem_en    = 1'b1;
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = wr_addr_q;
        bus.mem_wdata = wr_data_q;
        bus.d_wr_ack  = 1'b1;
        state_d       = IDLE;
      end
      FILL: begin
        bus.i_grant = !owner_d_q;
        bus.d_grant = owner_d_q;
        issue       = (iss_cnt_q != CNT_FULL);
        if (issue) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = base_q + (ADDR_W'(iss_cnt_q) << 1);
        end
        if (bus.mem_valid) begin
          bus.i_data_valid = !owner_d_q;
          bus.d_data_valid = owner_d_q;
          if (ret_cnt_q == CNT_LAST) begin
            bus.i_fill_done = !owner_d_q;
            bus.d_fill_done = owner_d_q;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Store operands are captured so the write cycle does not depend on the requester holding them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_d_q     <= 1'b0;
      base_q        <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      iss_cnt_q     <= '0;
      ret_cnt_q     <= '0;
`ifdef ARB_RR_EN
      last_fill_d_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          iss_cnt_q <= '0;
          ret_cnt_q <= '0;
          if (state_d == WRITE) begin
            wr_addr_q <= bus.d_wr_addr;
            wr_data_q <= bus.d_wr_data;
          end else if (state_d == FILL) begin
            owner_d_q     <= pick_d;
            base_q        <= (pick_d ? bus.d_addr : bus.i_addr) & LINE_MASK;
`ifdef ARB_RR_EN
            last_fill_d_q <= pick_d;
`endif
          end
        end
        FILL: begin
          if (issue)         iss_cnt_q <= iss_cnt_q + CW'(1);
          if (bus.mem_valid) ret_cnt_q <= ret_cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: cycle table for a plain I fill plus hand sequences
// for arbitration, store deferral, line-end addressing, reset mid-fill and stray returns.
module tb_cache_mem_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b();

  cache_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WORDS(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b)
  );

  // Memory: fixed 4-cycle read latency, not reset so in-flight reads survive a DUT reset.
  logic [3:0]  pv = '0;
  logic [15:0] pa [4];
  logic        stray_vld = 1'b0;

  function automatic logic [15:0] mdat(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  always @(posedge clk) begin
    pv    <= {pv[2:0], b.mem_en & ~b.mem_wr};
    pa[0] <= b.mem_addr;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
    pa[3] <= pa[2];
  end

  assign b.mem_valid = pv[3] | stray_vld;
  assign b.mem_rdata = pv[3] ? mdat(pa[3]) : 16'hDEAD;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [40:0] ctrl();
    return {b.i_grant, b.i_data_valid, b.i_fill_done, b.d_grant, b.d_data_valid,
            b.d_fill_done, b.d_wr_ack, b.mem_en, b.mem_wr, b.mem_addr, b.mem_wdata};
  endfunction

  typedef struct {
    logic        i_req;
    logic [8:0]  flags;  // i_grant,i_dv,i_done,d_grant,d_dv,d_done,d_wr_ack,mem_en,mem_wr
    logic [15:0] addr;
  } vec_t;

  function automatic vec_t mk(input logic rq, input logic g, input logic dv, input logic dn,
                              input logic en, input logic [15:0] a);
    vec_t v;
    v.i_req = rq;
    v.flags = {g, dv, dn, 1'b0, 1'b0, 1'b0, 1'b0, en, 1'b0};
    v.addr  = a;
    return v;
  endfunction

  task automatic wait_grant(output logic gd, output logic gi);
    gd = 1'b0;
    gi = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (b.d_grant || b.i_grant) begin
        gd = b.d_grant;
        gi = b.i_grant;
        break;
      end
    end
  endtask

  // Starts sampling in the current (grant) cycle and returns at the done cycle.
  task automatic observe_fill(input logic own_d, input logic [15:0] base, input string nm);
    int   n_iss = 0;
    int   n_ret = 0;
    int   bad   = 0;
    logic done  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      if ((own_d ? b.d_grant : b.i_grant) !== 1'b1) bad++;
      if ((own_d ? b.i_grant : b.d_grant) !== 1'b0) bad++;
      if (b.d_wr_ack !== 1'b0) bad++;
      if (b.mem_en) begin
        if (b.mem_wr !== 1'b0 || b.mem_addr !== base + 16'(2 * n_iss)) bad++;
        n_iss++;
      end
      if ((own_d ? b.i_data_valid : b.d_data_valid) !== 1'b0) bad++;
      if ((own_d ? b.i_fill_done : b.d_fill_done) !== 1'b0) bad++;
      if (own_d ? b.d_data_valid : b.i_data_valid) begin
        if (b.rd_data !== mdat(base + 16'(2 * n_ret))) bad++;
        n_ret++;
      end
      if (own_d ? b.d_fill_done : b.i_fill_done) begin
        if ((own_d ? b.d_data_valid : b.i_data_valid) !== 1'b1) bad++;
        done = 1'b1;
        break;
      end
    end
    check({nm, "_done"}, done, 1);
    check({nm, "_reads"}, n_iss, 8);
    check({nm, "_returns"}, n_ret, 8);
    check({nm, "_protocol"}, bad, 0);
  endtask

  vec_t tv[15];

  initial begin
    logic gd, gi;
    int   ri, n, bad;

    tv[0]  = mk(1, 0, 0, 0, 0, 16'h0000);
    tv[1]  = mk(1, 1, 0, 0, 1, 16'h1230);
    tv[2]  = mk(1, 1, 0, 0, 1, 16'h1232);
    tv[3]  = mk(1, 1, 0, 0, 1, 16'h1234);
    tv[4]  = mk(1, 1, 0, 0, 1, 16'h1236);
    tv[5]  = mk(1, 1, 1, 0, 1, 16'h1238);
    tv[6]  = mk(1, 1, 1, 0, 1, 16'h123A);
    tv[7]  = mk(1, 1, 1, 0, 1, 16'h123C);
    tv[8]  = mk(1, 1, 1, 0, 1, 16'h123E);
    tv[9]  = mk(1, 1, 1, 0, 0, 16'h0000);
    tv[10] = mk(1, 1, 1, 0, 0, 16'h0000);
    tv[11] = mk(1, 1, 1, 0, 0, 16'h0000);
    tv[12] = mk(1, 1, 1, 1, 0, 16'h0000);
    tv[13] = mk(0, 0, 0, 0, 0, 16'h0000);
    tv[14] = mk(0, 0, 0, 0, 0, 16'h0000);

    b.i_req = 0; b.i_addr = 0; b.d_req = 0; b.d_addr = 0;
    b.d_wr = 0; b.d_wr_addr = 0; b.d_wr_data = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", ctrl(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", ctrl(), 0);

    // Plain I fill, latency 4, one row per cycle.
    @(posedge clk); #1;
    b.i_addr = 16'h1233;
    ri = 0;
    for (int r = 0; r < 15; r++) begin
      b.i_req = tv[r].i_req;
      @(negedge clk);
      check($sformatf("t1_cycle%0d", r),
            {b.i_grant, b.i_data_valid, b.i_fill_done, b.d_grant, b.d_data_valid,
             b.d_fill_done, b.d_wr_ack, b.mem_en, b.mem_wr, (b.mem_en ? b.mem_addr : 16'h0)},
            {tv[r].flags, tv[r].addr});
      if (tv[r].flags[7]) begin
        check($sformatf("t1_data%0d", ri), b.rd_data, mdat(16'h1230 + 16'(2 * ri)));
        ri++;
      end
      @(posedge clk); #1;
    end

    // Simultaneous D and I fill requests.
    b.d_addr = 16'h2000;
    b.i_addr = 16'h3000;
    b.d_req  = 1'b1;
    b.i_req  = 1'b1;
`ifndef ARB_RR_EN
    wait_grant(gd, gi);
    check("t2_first_d", {gd, gi}, 2'b10);
    b.d_req = 1'b0;
    observe_fill(1'b1, 16'h2000, "t2_d");
    @(negedge clk);
    check("t2_gap", {b.i_grant, b.d_grant, b.mem_en}, 3'b000);
    @(negedge clk);
    check("t2_then_i", {b.i_grant, b.d_grant}, 2'b10);
    b.i_req = 1'b0;
    observe_fill(1'b0, 16'h3000, "t2_i");
`else
    for (int k = 0; k < 3; k++) begin
      wait_grant(gd, gi);
      check($sformatf("t2_rr_order%0d", k), {gd, gi}, (k == 1) ? 2'b01 : 2'b10);
      if (k == 2) begin
        b.d_req = 1'b0;
        b.i_req = 1'b0;
      end
      observe_fill(gd, gd ? 16'h2000 : 16'h3000, $sformatf("t2_rr%0d", k));
    end
`endif

    // Store arriving during an I fill is deferred until the fill completes.
    b.i_addr = 16'h4000;
    b.i_req  = 1'b1;
    wait_grant(gd, gi);
    check("t3_grant_i", {gd, gi}, 2'b01);
    b.i_req     = 1'b0;
    b.d_wr      = 1'b1;
    b.d_wr_addr = 16'h00A4;
    b.d_wr_data = 16'hBEEF;
    observe_fill(1'b0, 16'h4000, "t3_i");
    @(negedge clk);
    check("t3_idle_no_ack", ctrl(), 0);
    @(negedge clk);
    check("t3_write", ctrl(), {7'b0000001, 1'b1, 1'b1, 16'h00A4, 16'hBEEF});
    b.d_wr = 1'b0;
    @(negedge clk);
    check("t3_after_write", ctrl(), 0);

    // Line at the top of the address space.
    b.d_addr = 16'hFFF7;
    b.d_req  = 1'b1;
    wait_grant(gd, gi);
    check("t4_grant_d", {gd, gi}, 2'b10);
    b.d_req = 1'b0;
    observe_fill(1'b1, 16'hFFF0, "t4_d");
    @(negedge clk);
    check("t4_no_ninth_read", {b.mem_en, b.d_grant}, 2'b00);

    // Reset after three returns; remaining returns must be ignored.
    b.i_addr = 16'h0500;
    b.i_req  = 1'b1;
    wait_grant(gd, gi);
    check("t5_grant_i", {gd, gi}, 2'b01);
    b.i_req = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (b.i_data_valid) n++;
      if (n == 3) break;
    end
    check("t5_three_returns", n, 3);
    rst_n = 1'b0;
    #1;
    check("t5_reset_now", ctrl(), 0);
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 1) rst_n = 1'b1;
      if (b.i_data_valid || b.d_data_valid || b.i_fill_done || b.d_fill_done ||
          b.i_grant || b.d_grant) bad++;
    end
    check("t5_no_stray_dv", bad, 0);
    b.i_addr = 16'h0600;
    b.i_req  = 1'b1;
    wait_grant(gd, gi);
    check("t5_regrant_i", {gd, gi}, 2'b01);
    b.i_req = 1'b0;
    observe_fill(1'b0, 16'h0600, "t5_refill");

    // Stray return in IDLE, then a fill whose request drops right after grant.
    @(negedge clk);
    stray_vld = 1'b1;
    #1;
    check("t6_stray_ignored", ctrl(), 0);
    @(posedge clk); #1;
    stray_vld = 1'b0;
    b.i_addr = 16'h0700;
    b.i_req  = 1'b1;
    wait_grant(gd, gi);
    check("t6_grant_i", {gd, gi}, 2'b01);
    b.i_req = 1'b0;
    observe_fill(1'b0, 16'h0700, "t6_drop");
    @(negedge clk);
    check("t6_back_idle", ctrl(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
